// File: rtl/i2c_target.sv
// i2c_target: I2C responder at a fixed 7-bit address that emulates a small
// EEPROM-style byte array (pointer write, sequential writes, current-address
// and random reads). SCL/SDA are oversampled on clk; SDA is open-drain.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         MEM_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  input  logic                         load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [7:0]                   load_data,
  output logic                         wr_valid,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         busy
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_RX_PTR, ST_RX_DATA,
    ST_ACK_RX, ST_TX_DATA, ST_RX_ACK, ST_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic            scl_p0, scl_p1, scl_p2, sda_p0, sda_p1, sda_p2;
  logic            scl_rise, scl_fall, start_det, stop_det;
  logic            sda_oe_nxt, busy_nxt, rw, rw_nxt, nack, nack_nxt;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt, rx_byte, tx_byte;
  logic [AW-1:0]   ptr, ptr_nxt, wr_addr_nxt;
  logic            wr_valid_nxt, commit;
  logic [7:0]      wr_data_nxt;
  logic [7:0]      mem [MEM_DEPTH];

  // Pad synchronizers: _p1 is the synced level, _p2 the previous sample; idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_i; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & ~sda_p2 & sda_p1;
  assign rx_byte   = {shift[6:0], sda_p1};
  assign tx_byte   = mem[ptr];

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      ptr      <= '0;
      rw       <= 1'b0;
      nack     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      ptr      <= ptr_nxt;
      rw       <= rw_nxt;
      nack     <= nack_nxt;
      wr_valid <= wr_valid_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  // Bus protocol: START/STOP override everything, otherwise act on SCL edges
  always_comb begin
    state_nxt    = state;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    ptr_nxt      = ptr;
    rw_nxt       = rw;
    nack_nxt     = nack;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    commit       = 1'b0;
    if (stop_det) begin
      state_nxt  = ST_IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 4'd0;
      shift_nxt   = 8'h00;
      sda_oe_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR, ST_RX_PTR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = 4'd0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state_nxt = ST_ACK_ADDR;
                  rw_nxt    = rx_byte[0];
                end else begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
                end
              end else if (state == ST_RX_PTR) begin
                ptr_nxt   = rx_byte[AW-1:0];
                state_nxt = ST_ACK_RX;
              end else begin
                commit       = 1'b1;
                wr_valid_nxt = 1'b1;
                wr_addr_nxt  = ptr;
                wr_data_nxt  = rx_byte;
                ptr_nxt      = ptr + 1'b1;
                state_nxt    = ST_ACK_RX;
              end
            end
          end
        end
        ST_ACK_ADDR: begin
          // sda_oe doubles as the "ACK already driven" flag
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              busy_nxt = 1'b1;
              if (rw) begin
                state_nxt   = ST_TX_DATA;
                shift_nxt   = {tx_byte[6:0], 1'b0};
                sda_oe_nxt  = ~tx_byte[7];
                bit_cnt_nxt = 4'd1;
              end else begin
                state_nxt  = ST_RX_PTR;
                sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        ST_ACK_RX: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_RX_DATA;
            end
          end
        end
        ST_TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_RX_ACK;
            end else begin
              sda_oe_nxt  = ~shift[7];
              shift_nxt   = {shift[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        ST_RX_ACK: begin
          // bit_cnt 8 = waiting for the ACK rise, 9 = ACK sampled, waiting for the fall
          if (scl_rise && bit_cnt == 4'd8) begin
            nack_nxt    = sda_p1;
            ptr_nxt     = ptr + 1'b1;
            bit_cnt_nxt = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            if (nack) begin
              state_nxt = ST_HOLD;
            end else begin
              state_nxt   = ST_TX_DATA;
              shift_nxt   = {tx_byte[6:0], 1'b0};
              sda_oe_nxt  = ~tx_byte[7];
              bit_cnt_nxt = 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Byte array: I2C commit first, host load last so the host wins on a shared address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (commit)  mem[ptr] <= rx_byte;
      if (load_en) mem[load_addr] <= load_data;
    end
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

Clocked I2C target (responder) that emulates a small EEPROM/EDID-style register space at a fixed 7-bit address, so the I2C controller on the `gp` pins can be exercised end-to-end on-board without an external device. It oversamples SCL/SDA on the system clock, detects START/STOP, ACKs its own address, and accepts a pointer byte followed by data writes. It supports repeated-start and current-address sequential reads from an internal byte array, which a host-side load port can preload. SDA is open-drain: the block only ever pulls low.

## Interface
- `TARGET_ADDR`, 7'h50: 7-bit address this target responds to.
- `MEM_DEPTH`, 16: bytes of internal storage; power of two, 2..256; pointer wraps modulo `MEM_DEPTH`.
- `clk` in 1: system clock; must be ≥16× the SCL frequency.
- `rst_n` in 1: reset, asynchronous, active-low.
- `scl_i` in 1: raw SCL from pad (asynchronous).
- `sda_i` in 1: raw SDA from pad (asynchronous).
- `sda_oe` out 1: 1 = pull SDA low; 0 = release (pad tristate).
- `load_en` in 1: host write strobe into memory.
- `load_addr` in $clog2(MEM_DEPTH): host write address.
- `load_data` in 8: host write data.
- `wr_valid` out 1: one-cycle pulse when an I2C data byte is committed to memory.
- `wr_addr` out $clog2(MEM_DEPTH): address of the committed byte.
- `wr_data` out 8: value of the committed byte.
- `busy` out 1: high from an address-matched ACK until STOP, address mismatch, or reset.

## Operation
- Input conditioning: 2-FF synchronizer on each of `scl_i` and `sda_i`, plus one delayed copy of each for edge detection.
- SCL rise (`scl` 0→1) = sample point. SCL fall = drive point.
- START: synced SDA 1→0 while synced SCL = 1. Valid in every state, including as a repeated START. Action: bit counter → 0, shift register cleared, state → ADDR, `sda_oe` ← 0.
- STOP: synced SDA 0→1 while synced SCL = 1. Valid in every state. Action: state → IDLE, `sda_oe` ← 0, `busy` ← 0.
- START/STOP take priority over any SCL edge in the same cycle.
- States and transitions:
  - IDLE: ignore the bus; leave only on START.
  - ADDR: shift 8 bits MSB first on SCL rises.
    - After the 8th rise, if bits[7:1] == `TARGET_ADDR`: → ACK_ADDR, latch R/W = bit0.
    - Otherwise → IDLE; no ACK, no other effect.
  - ACK_ADDR: assert `sda_oe` on the SCL fall after the 8th bit. Release it on the following SCL fall; `busy` ← 1 at that point.
    - W → RX_PTR.
    - R → TX_DATA, loading the shift register from mem[ptr] on that same fall.
  - RX_PTR: receive 8 bits, then ptr ← byte mod `MEM_DEPTH`. ACK as above, then → RX_DATA.
  - RX_DATA: receive 8 bits, then mem[ptr] ← byte and ptr ← ptr+1 (wrapping). ACK as above, then stay in RX_DATA.
    - One-cycle `wr_valid` pulse with `wr_addr` = old ptr and `wr_data` = byte, in the cycle after the 8th SCL rise.
  - TX_DATA: drive `sda_oe` = ~shift[7] on each SCL fall and shift left. After 8 bits, release SDA on the 8th-bit fall → RX_ACK.
  - RX_ACK: sample SDA on the 9th SCL rise; ptr ← ptr+1 (wrapping).
    - ACK (0): on the next fall, load mem[ptr] → TX_DATA.
    - NACK (1): → IDLE-like hold with SDA released, waiting for STOP/START; `busy` stays 1 until STOP.
- The pointer persists across transactions and is not cleared by START/STOP. This provides EEPROM semantics: write-pointer then repeated-START read gives a random read; a bare read gives a current-address read.
- Host port: `load_en` writes `load_data` to mem[`load_addr`] on the clock edge.
  - If the host write and an I2C commit hit the same address in the same cycle, the host write wins; `wr_valid` still pulses.
  - Commits to different addresses in the same cycle both take effect.
- No clock stretching; general-call address 0x00 is not acknowledged.

## Timing
- Reset values: `sda_oe`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, ptr=0, memory all 0x00, state IDLE.
- Asserting `rst_n` mid-transfer forces `sda_oe` low asynchronously, within the same cycle.
- Pad→decision latency: 3 `clk` cycles (2 sync + 1 edge). `sda_oe` changes 3–4 `clk` after the SCL fall at the pad, well inside tLOW at ≥16× oversampling.
- A TX byte is read from memory on the fall edge that starts it; a host load to that address after that edge does not affect the byte in flight.
- A STOP or START in the middle of a byte aborts it. A partial RX byte is discarded; no `wr_valid`.

## Test plan
- Preload mem[0..3]=A5,3C,0F,F0. Bus: START, A0, 00, rSTART, A1, read 4 (ACK,ACK,ACK,NACK), STOP → ACK on A0/00/A1; bytes A5,3C,0F,F0 on SDA; ptr=4; `busy` 0 after STOP.
- START, A1, read 1, NACK, STOP, with ptr=4 and mem[4]=0x77 → byte 0x77 returned; ptr=5.
- START, A0, 0E, 11, 22, 33, STOP → `wr_valid` ×3 with (0E,11), (0F,22), (00,33); mem reflects the writes (wrap verified).
- START, A4 (address 0x52), STOP → SDA never pulled low; `busy`=0; no `wr_valid`; memory unchanged.
- Read in progress, STOP injected after 3 data bits → `sda_oe`=0 within 4 `clk`; a following A0/00/A1 read returns correct data.
- `rst_n` low while `sda_oe`=1 during ACK → `sda_oe`=0 immediately; ptr=0; memory 0x00; the bus recovers on the next START.
